// File: rtl/subleq_loader_pkg.sv
// rtl/subleq_loader_pkg.sv - loader state encodings and frame constants
package subleq_loader_pkg;

  typedef enum logic [2:0] {
    LD_IDLE  = 3'd0,
    LD_LOAD  = 3'd1,
    LD_CHECK = 3'd2,
    LD_RUN   = 3'd3,
    LD_ERR   = 3'd4
  } ld_state_t;

  localparam int LD_LEN_MAX = 256;

endpackage

// File: rtl/subleq_loader.sv
// rtl/subleq_loader.sv - length-prefixed, checksummed boot image loader for SUBLEQ RAM
module subleq_loader
  import subleq_loader_pkg::*;
#(
  parameter int ADR_W = 8,
  parameter int DAT_W = 8,
  parameter logic [ADR_W-1:0] START_ADR = '0
) (
  input  logic             clk,
  input  logic             res,
  input  logic             in_valid,
  input  logic [DAT_W-1:0] in_data,
  output logic             in_ready,
  input  logic             load_req,
  output logic             ld_we,
  output logic [ADR_W-1:0] ld_adr,
  output logic [DAT_W-1:0] ld_dat,
  output logic             core_hold,
  output logic             done,
  output logic             err
);

  localparam logic [ADR_W-1:0] ADR_ONE = ADR_W'(1);

  ld_state_t        state;
  ld_state_t        state_nxt;
  logic [8:0]       cnt;
  logic [8:0]       cnt_init;
  logic [DAT_W-1:0] sum;
  logic [DAT_W-1:0] sum_add;
  logic             accept;

  assign accept   = in_valid & in_ready;
  assign sum_add  = sum + in_data;
  // A length byte of zero encodes a full 256-byte image.
  assign cnt_init = (in_data == '0) ? 9'(LD_LEN_MAX) : 9'(in_data);

  always_ff @(posedge clk) begin
    if (res) state <= LD_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      LD_IDLE:  if (accept) state_nxt = LD_LOAD;
      LD_LOAD:  if (accept && cnt == 9'd1) state_nxt = LD_CHECK;
      LD_CHECK: if (accept) state_nxt = (sum_add == '0) ? LD_RUN : LD_ERR;
      LD_RUN:   if (load_req) state_nxt = LD_IDLE;
      LD_ERR:   state_nxt = LD_ERR;
      default:  state_nxt = LD_IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state == LD_IDLE) || (state == LD_LOAD) || (state == LD_CHECK);
    core_hold = (state != LD_RUN);
    done      = (state == LD_RUN);
    err       = (state == LD_ERR);
  end

  // Address is pre-decremented in IDLE so every LOAD accept is a plain increment.
  always_ff @(posedge clk) begin
    if (res) begin
      cnt    <= '0;
      sum    <= '0;
      ld_adr <= START_ADR;
      ld_dat <= '0;
      ld_we  <= 1'b0;
    end else begin
      ld_we <= 1'b0;
      if (accept && state == LD_IDLE) begin
        cnt    <= cnt_init;
        sum    <= '0;
        ld_adr <= START_ADR - ADR_ONE;
      end else if (accept && state == LD_LOAD) begin
        ld_dat <= in_data;
        ld_adr <= ld_adr + ADR_ONE;
        ld_we  <= 1'b1;
        sum    <= sum_add;
        cnt    <= cnt - 9'd1;
      end
    end
  end

endmodule

// File: tb/tb_subleq_loader.sv
// tb/tb_subleq_loader.sv - directed self-checking bench for subleq_loader
module tb_subleq_loader;
  import subleq_loader_pkg::*;

  logic       clk = 1'b0;
  logic       res = 1'b1;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       load_req = 1'b0;

  logic       in_ready0, ld_we0, core_hold0, done0, err0;
  logic [7:0] ld_adr0, ld_dat0;
  logic       in_ready1, ld_we1, core_hold1, done1, err1;
  logic [7:0] ld_adr1, ld_dat1;

  int tests_run = 0;
  int tests_failed = 0;
  int wr0 = 0;

  subleq_loader #(.ADR_W(8), .DAT_W(8), .START_ADR(8'h00)) dut0 (
    .clk(clk), .res(res), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready0),
    .load_req(load_req), .ld_we(ld_we0), .ld_adr(ld_adr0), .ld_dat(ld_dat0),
    .core_hold(core_hold0), .done(done0), .err(err0)
  );

  subleq_loader #(.ADR_W(8), .DAT_W(8), .START_ADR(8'hF0)) dut1 (
    .clk(clk), .res(res), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready1),
    .load_req(load_req), .ld_we(ld_we1), .ld_adr(ld_adr1), .ld_dat(ld_dat1),
    .core_hold(core_hold1), .done(done1), .err(err1)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (ld_we0) wr0++;

  task automatic do_reset();
    @(negedge clk);
    res = 1'b1; in_valid = 1'b0; load_req = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    res = 1'b0;
    wr0 = 0;
  endtask

  task automatic send(input logic [7:0] b);
    @(negedge clk);
    in_valid = 1'b1; in_data = b;
    @(posedge clk); #1;
  endtask

  task automatic idle();
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    res = 1'b1;
    @(posedge clk); #1;
    tests_run++; if (dut0.state !== LD_IDLE) begin tests_failed++; $display("FAIL rst_state got %0d exp %0d", dut0.state, LD_IDLE); end
    tests_run++; if ({in_ready0, ld_we0, core_hold0, done0, err0} !== 5'b10100) begin tests_failed++; $display("FAIL rst_flags got %b exp 10100", {in_ready0, ld_we0, core_hold0, done0, err0}); end
    tests_run++; if (ld_adr0 !== 8'h00 || ld_dat0 !== 8'h00) begin tests_failed++; $display("FAIL rst_adr_dat got %h/%h exp 00/00", ld_adr0, ld_dat0); end
    tests_run++; if (ld_adr1 !== 8'hF0) begin tests_failed++; $display("FAIL rst_adr_f0 got %h exp f0", ld_adr1); end
    @(negedge clk);
    res = 1'b0;
  endtask

  task automatic test_basic();
    logic [7:0] d [3] = '{8'h0A, 8'h0B, 8'h0C};
    do_reset();
    send(8'h03);
    tests_run++; if (ld_we0 !== 1'b0) begin tests_failed++; $display("FAIL t1_len_we got %b exp 0", ld_we0); end
    for (int i = 0; i < 3; i++) begin
      send(d[i]);
      tests_run++; if (ld_we0 !== 1'b1 || ld_adr0 !== 8'(i) || ld_dat0 !== d[i]) begin
        tests_failed++; $display("FAIL t1_write%0d got we=%b %h:%h exp 1 %h:%h", i, ld_we0, ld_adr0, ld_dat0, 8'(i), d[i]);
      end
    end
    tests_run++; if (done0 !== 1'b0 || in_ready0 !== 1'b1) begin tests_failed++; $display("FAIL t1_check_state got done=%b rdy=%b exp 0 1", done0, in_ready0); end
    send(8'hDF);
    tests_run++; if ({ld_we0, done0, core_hold0, in_ready0, err0} !== 5'b01000) begin tests_failed++; $display("FAIL t1_done got %b exp 01000", {ld_we0, done0, core_hold0, in_ready0, err0}); end
    idle();
    tests_run++; if (wr0 !== 3) begin tests_failed++; $display("FAIL t1_wr_count got %0d exp 3", wr0); end
    send(8'h44);
    tests_run++; if (ld_we0 !== 1'b0 || done0 !== 1'b1) begin tests_failed++; $display("FAIL t1_run_ignore got we=%b done=%b exp 0 1", ld_we0, done0); end
    idle();
  endtask

  task automatic test_bad_csum();
    do_reset();
    send(8'h02); send(8'h11); send(8'h22);
    tests_run++; if (ld_adr0 !== 8'h01 || ld_dat0 !== 8'h22) begin tests_failed++; $display("FAIL t2_last_write got %h:%h exp 01:22", ld_adr0, ld_dat0); end
    send(8'h00);
    tests_run++; if ({err0, core_hold0, in_ready0, done0} !== 4'b1100) begin tests_failed++; $display("FAIL t2_err got %b exp 1100", {err0, core_hold0, in_ready0, done0}); end
    send(8'h55);
    tests_run++; if (ld_we0 !== 1'b0 || err0 !== 1'b1) begin tests_failed++; $display("FAIL t2_no_write got we=%b err=%b exp 0 1", ld_we0, err0); end
    idle();
    tests_run++; if (wr0 !== 2) begin tests_failed++; $display("FAIL t2_wr_count got %0d exp 2", wr0); end
  endtask

  task automatic test_wrap_256();
    int bad = 0;
    do_reset();
    send(8'h00);
    for (int i = 0; i < 256; i++) begin
      send(8'(i));
      if (ld_we1 !== 1'b1 || ld_adr1 !== 8'(8'hF0 + i) || ld_dat1 !== 8'(i)) begin
        if (bad == 0) $display("FAIL t3_write%0d got we=%b %h:%h exp 1 %h:%h", i, ld_we1, ld_adr1, ld_dat1, 8'(8'hF0 + i), 8'(i));
        bad++;
      end
    end
    tests_run++; if (bad !== 0) begin tests_failed++; $display("FAIL t3_bad_writes got %0d exp 0", bad); end
    tests_run++; if (done1 !== 1'b0 || in_ready1 !== 1'b1) begin tests_failed++; $display("FAIL t3_check_state got done=%b rdy=%b exp 0 1", done1, in_ready1); end
    send(8'h80);
    tests_run++; if (done1 !== 1'b1 || core_hold1 !== 1'b0 || done0 !== 1'b1) begin tests_failed++; $display("FAIL t3_done got %b%b%b exp 101", done1, core_hold1, done0); end
    idle();
    tests_run++; if (wr0 !== 256) begin tests_failed++; $display("FAIL t3_wr_count got %0d exp 256", wr0); end
  endtask

  task automatic test_gaps();
    do_reset();
    send(8'h03); idle();
    for (int i = 0; i < 3; i++) begin
      send(8'(i + 1));
      tests_run++; if (ld_we0 !== 1'b1 || ld_adr0 !== 8'(i) || ld_dat0 !== 8'(i + 1)) begin
        tests_failed++; $display("FAIL t4_write%0d got we=%b %h:%h exp 1 %h:%h", i, ld_we0, ld_adr0, ld_dat0, 8'(i), 8'(i + 1));
      end
      idle();
      tests_run++; if (ld_we0 !== 1'b0 || ld_adr0 !== 8'(i)) begin tests_failed++; $display("FAIL t4_gap%0d got we=%b adr=%h exp 0 %h", i, ld_we0, ld_adr0, 8'(i)); end
    end
    send(8'hFA);
    tests_run++; if (done0 !== 1'b1) begin tests_failed++; $display("FAIL t4_done got %b exp 1", done0); end
    idle();
    tests_run++; if (wr0 !== 3) begin tests_failed++; $display("FAIL t4_wr_count got %0d exp 3", wr0); end
  endtask

  task automatic test_mid_reset();
    do_reset();
    send(8'h05); send(8'h01); send(8'h02);
    @(negedge clk);
    in_valid = 1'b0; res = 1'b1;
    @(posedge clk); #1;
    tests_run++; if (dut0.state !== LD_IDLE || {ld_we0, core_hold0, done0, in_ready0} !== 4'b0101) begin
      tests_failed++; $display("FAIL t5_reset got st=%0d flags=%b exp %0d 0101", dut0.state, {ld_we0, core_hold0, done0, in_ready0}, LD_IDLE);
    end
    @(negedge clk);
    res = 1'b0;
    send(8'h02); send(8'h7F);
    tests_run++; if (ld_we0 !== 1'b1 || ld_adr0 !== 8'h00 || ld_dat0 !== 8'h7F) begin tests_failed++; $display("FAIL t5_restart got we=%b %h:%h exp 1 00:7f", ld_we0, ld_adr0, ld_dat0); end
    send(8'h81); send(8'h00);
    tests_run++; if (done0 !== 1'b1 || ld_adr0 !== 8'h01) begin tests_failed++; $display("FAIL t5_done got done=%b adr=%h exp 1 01", done0, ld_adr0); end
    idle();
  endtask

  task automatic test_reload();
    @(negedge clk);
    load_req = 1'b1; in_valid = 1'b1; in_data = 8'h99;
    @(posedge clk); #1;
    tests_run++; if ({core_hold0, done0, in_ready0, ld_we0} !== 4'b1010) begin tests_failed++; $display("FAIL t6_reload got %b exp 1010", {core_hold0, done0, in_ready0, ld_we0}); end
    @(negedge clk);
    load_req = 1'b0; in_valid = 1'b0;
    wr0 = 0;
    send(8'h02); send(8'h40);
    tests_run++; if (ld_we0 !== 1'b1 || ld_adr0 !== 8'h00 || ld_dat0 !== 8'h40) begin tests_failed++; $display("FAIL t6_write0 got we=%b %h:%h exp 1 00:40", ld_we0, ld_adr0, ld_dat0); end
    send(8'hC0);
    tests_run++; if (ld_adr0 !== 8'h01 || ld_dat0 !== 8'hC0) begin tests_failed++; $display("FAIL t6_write1 got %h:%h exp 01:c0", ld_adr0, ld_dat0); end
    send(8'h00);
    tests_run++; if (done0 !== 1'b1 || core_hold0 !== 1'b0) begin tests_failed++; $display("FAIL t6_done got %b%b exp 10", done0, core_hold0); end
    idle();
    tests_run++; if (wr0 !== 2) begin tests_failed++; $display("FAIL t6_wr_count got %0d exp 2", wr0); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_bad_csum();
    test_wrap_256();
    test_gaps();
    test_mid_reset();
    test_reload();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
